// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole mole scheduler.
// Imported by the interface, the LFSR and the scheduler top.
package whack_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GAP,
      S_UP,
      S_FLASH
   } state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int MS_CNT_W = 11;
   localparam int IDX_W    = 3;

   localparam int GAP_MS_DEF   = 300;
   localparam int UP_MS_0_DEF  = 1200;
   localparam int UP_MS_1_DEF  = 800;
   localparam int UP_MS_2_DEF  = 500;
   localparam int UP_MS_3_DEF  = 500;
   localparam int FLASH_MS_DEF = 150;

   // Never repeat the previous mole: bump to the neighbour instead.
   function automatic logic [IDX_W-1:0] pick_idx(
      input logic [IDX_W-1:0] rnd,
      input logic [IDX_W-1:0] prev
   );
      if (rnd == prev) return rnd + 1'b1;
      return rnd;
   endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Game-side and board-side signals of the mole scheduler.
// master drives the controls, slave is the scheduler.
interface mole_scheduler_if;

   logic       enable;
   logic [1:0] difficulty;
   logic       tick_ms;
   logic [7:0] whack;
   logic [7:0] mole_leds;
   logic [2:0] active_idx;
   logic       hit_pulse;
   logic       miss_pulse;

   modport master (
      output enable, difficulty, tick_ms, whack,
      input  mole_leds, active_idx, hit_pulse, miss_pulse
   );

   modport slave (
      input  enable, difficulty, tick_ms, whack,
      output mole_leds, active_idx, hit_pulse, miss_pulse
   );

endinterface

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR, free-running every clock out of reset.
// Only the low OUT_W bits are exported as the random value.
module mole_lfsr
   import whack_pkg::*;
#(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          OUT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [OUT_W-1:0] rnd_o
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign rnd_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mole_scheduler.sv
// Picks a pseudo-random mole, lights it for a difficulty-dependent
// time, judges whacks and emits registered hit/miss pulses.
module mole_scheduler
   import whack_pkg::*;
#(
   parameter int          NUM_MOLES = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          GAP_MS    = GAP_MS_DEF,
   parameter int          UP_MS_0   = UP_MS_0_DEF,
   parameter int          UP_MS_1   = UP_MS_1_DEF,
   parameter int          UP_MS_2   = UP_MS_2_DEF,
   parameter int          UP_MS_3   = UP_MS_3_DEF,
   parameter int          FLASH_MS  = FLASH_MS_DEF
) (
   input logic             clk,
   input logic             rst_n,
   mole_scheduler_if.slave bus
);

   typedef logic [MS_CNT_W-1:0] ms_t;

   localparam ms_t GAP_END   = ms_t'(GAP_MS - 1);
   localparam ms_t FLASH_END = ms_t'(FLASH_MS - 1);

   state_e               state_q, state_d;
   ms_t                  cnt_q, cnt_d, cnt_inc;
   ms_t                  up_q, up_d, up_sel;
   logic [IDX_W-1:0]     idx_q, idx_d, rnd;
   logic [NUM_MOLES-1:0] leds_q, leds_d;
   logic                 hit_q, hit_d;
   logic                 miss_q, miss_d;
   logic                 tmo, wrong;

   mole_lfsr #(
      .SEED  (LFSR_SEED),
      .OUT_W (IDX_W)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .rnd_o (rnd)
   );

   always_comb begin
      unique case (bus.difficulty)
         2'd0:    up_sel = ms_t'(UP_MS_0);
         2'd1:    up_sel = ms_t'(UP_MS_1);
         2'd2:    up_sel = ms_t'(UP_MS_2);
         default: up_sel = ms_t'(UP_MS_3);
      endcase
   end

   // idx_q doubles as prev_idx: both always take the same pick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      up_d    = up_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      cnt_inc = cnt_q + ms_t'(1);
      tmo     = bus.tick_ms && (cnt_q == up_q - ms_t'(1));
      wrong   = |bus.whack;

      unique case (state_q)
         S_IDLE: begin
            if (bus.enable) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (bus.tick_ms) begin
               if (cnt_q == GAP_END) begin
                  idx_d   = pick_idx(rnd, idx_q);
                  up_d    = up_sel;
                  cnt_d   = '0;
                  state_d = S_UP;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_UP: begin
            if (bus.whack[idx_q]) begin
               hit_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_FLASH;
            end else if (wrong || tmo) begin
               // A wrong whack on the timeout tick yields one miss.
               miss_d = 1'b1;
               if (tmo) begin
                  cnt_d   = '0;
                  state_d = S_GAP;
               end else if (bus.tick_ms) begin
                  cnt_d = cnt_inc;
               end
            end else if (bus.tick_ms) begin
               cnt_d = cnt_inc;
            end
         end
         S_FLASH: begin
            if (bus.tick_ms) begin
               if (cnt_q == FLASH_END) begin
                  cnt_d   = '0;
                  state_d = S_GAP;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Disable wins, but a whack in the last enabled cycle is judged.
      if (!bus.enable) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         idx_d   = idx_q;
         up_d    = up_q;
         miss_d  = miss_d && wrong;
      end

      leds_d = '0;
      if (state_d == S_UP)
         leds_d = {{(NUM_MOLES-1){1'b0}}, 1'b1} << idx_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         up_q    <= ms_t'(UP_MS_0);
         idx_q   <= '0;
         leds_q  <= '0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         up_q    <= up_d;
         idx_q   <= idx_d;
         leds_q  <= leds_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   assign bus.mole_leds  = leds_q;
   assign bus.active_idx = idx_q;
   assign bus.hit_pulse  = hit_q;
   assign bus.miss_pulse = miss_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with short ms constants.
// tick_ms every 4 clocks; LFSR choice tracked by a bench model.
`timescale 1ns/1ps
module tb_mole_scheduler;

   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mole_scheduler_if bus();

   mole_scheduler #(
      .GAP_MS   (3),
      .UP_MS_0  (5),
      .FLASH_MS (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int nticks = 0;
   int nhit = 0;
   int nmiss = 0;
   int nboth = 0;
   int phase = 0;
   logic tick_en = 1'b0;
   logic [15:0] lf_m, lf_last;
   logic [2:0] prev_m = 3'd0;

   initial begin
      bus.tick_ms = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.tick_ms = tick_en && (phase == 3);
         phase = (phase + 1) % 4;
      end
   end

   always @(posedge clk) if (rst_n && bus.tick_ms) nticks++;

   always @(negedge clk) begin
      if (bus.hit_pulse) nhit++;
      if (bus.miss_pulse) nmiss++;
      if (bus.hit_pulse && bus.miss_pulse) nboth++;
   end

   // Reference Galois LFSR; lf_last is the value the DUT saw at the last edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lf_m = SEED;
         lf_last = SEED;
      end else begin
         lf_last = lf_m;
         lf_m = lf_m[0] ? ((lf_m >> 1) ^ 16'hB400) : (lf_m >> 1);
      end
   end

   function automatic logic [2:0] pick(logic [15:0] l, logic [2:0] p);
      logic [2:0] r;
      r = l[2:0];
      return (r == p) ? r + 3'd1 : r;
   endfunction

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_leds(input bit lit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         if ((bus.mole_leds != 8'd0) == lit) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic next_mole(output bit ok, output logic [2:0] k);
      wait_leds(1'b1, ok);
      k = pick(lf_last, prev_m);
      prev_m = k;
   endtask

   task automatic do_whack(input logic [7:0] v);
      @(posedge clk);
      #2 bus.whack = v;
      @(posedge clk);
      #2 bus.whack = 8'd0;
      step();
   endtask

   task automatic test_reset;
      step();
      tests++;
      if (bus.mole_leds !== 8'd0 || bus.active_idx !== 3'd0) begin
         fails++;
         $display("FAIL reset_leds_idx: got leds=%h idx=%0d, want 00/0",
                  bus.mole_leds, bus.active_idx);
      end
      tests++;
      if (bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin
         fails++;
         $display("FAIL reset_pulses: got hit=%b miss=%b, want 0/0",
                  bus.hit_pulse, bus.miss_pulse);
      end
   endtask

   task automatic test_timeout;
      bit ok;
      int base, m0;
      logic [2:0] k, k2;
      @(posedge clk);
      #2 bus.enable = 1'b1;
      @(posedge clk);
      step();
      base = nticks;
      next_mole(ok, k);
      tests++;
      if (!ok) begin fails++; $display("FAIL t1_light: no mole, want lit"); end
      tests++;
      if (nticks - base !== 3) begin
         fails++;
         $display("FAIL t1_gap_ticks: got %0d, want 3", nticks - base);
      end
      tests++;
      if (bus.active_idx !== k || bus.mole_leds !== (8'b1 << k)) begin
         fails++;
         $display("FAIL t1_idx: got idx=%0d leds=%h, want %0d", bus.active_idx, bus.mole_leds, k);
      end
      base = nticks;
      m0 = nmiss;
      wait_leds(1'b0, ok);
      tests++;
      if (!ok || bus.miss_pulse !== 1'b1 || bus.hit_pulse !== 1'b0) begin
         fails++;
         $display("FAIL t1_timeout_miss: got miss=%b hit=%b, want 1/0",
                  bus.miss_pulse, bus.hit_pulse);
      end
      tests++;
      if (nticks - base !== 5) begin
         fails++;
         $display("FAIL t1_up_ticks: got %0d, want 5", nticks - base);
      end
      step();
      tests++;
      if (nmiss - m0 !== 1 || bus.miss_pulse !== 1'b0) begin
         fails++;
         $display("FAIL t1_one_miss: got %0d misses, want 1", nmiss - m0);
      end
      next_mole(ok, k2);
      tests++;
      if (!ok || bus.active_idx !== k2 || bus.active_idx === k) begin
         fails++;
         $display("FAIL t1_next_idx: got %0d, want %0d (prev %0d)", bus.active_idx, k2, k);
      end
   endtask

   task automatic test_hit;
      bit ok;
      int base, m0, h0;
      logic [2:0] k, k2;
      k = prev_m;
      do_whack(8'b1 << k);
      tests++;
      if (bus.hit_pulse !== 1'b1 || bus.miss_pulse !== 1'b0 || bus.mole_leds !== 8'd0) begin
         fails++;
         $display("FAIL t2_hit: got hit=%b miss=%b leds=%h, want 1/0/00",
                  bus.hit_pulse, bus.miss_pulse, bus.mole_leds);
      end
      base = nticks;
      m0 = nmiss;
      h0 = nhit;
      next_mole(ok, k2);
      tests++;
      if (!ok || nticks - base !== 5) begin
         fails++;
         $display("FAIL t2_flash_gap: got %0d ticks, want 5", nticks - base);
      end
      tests++;
      if (nmiss !== m0 || nhit !== h0) begin
         fails++;
         $display("FAIL t2_no_pulse: got %0d miss %0d hit, want 0/0", nmiss - m0, nhit - h0);
      end
      tests++;
      if (bus.active_idx !== k2) begin
         fails++;
         $display("FAIL t2_idx: got %0d, want %0d", bus.active_idx, k2);
      end
   endtask

   task automatic test_wrong;
      bit ok;
      int base, m0, h0;
      logic [2:0] k;
      k = prev_m;
      base = nticks;
      m0 = nmiss;
      h0 = nhit;
      do_whack(8'b1 << ((k + 3'd1) % 8));
      tests++;
      if (bus.miss_pulse !== 1'b1 || bus.hit_pulse !== 1'b0 || bus.mole_leds !== (8'b1 << k)) begin
         fails++;
         $display("FAIL t3_wrong: got miss=%b hit=%b leds=%h, want 1/0/lit",
                  bus.miss_pulse, bus.hit_pulse, bus.mole_leds);
      end
      wait_leds(1'b0, ok);
      tests++;
      if (!ok || nticks - base !== 5 || bus.miss_pulse !== 1'b1) begin
         fails++;
         $display("FAIL t3_timeout: got %0d ticks miss=%b, want 5/1", nticks - base, bus.miss_pulse);
      end
      tests++;
      if (nmiss - m0 !== 2 || nhit !== h0) begin
         fails++;
         $display("FAIL t3_counts: got %0d miss %0d hit, want 2/0", nmiss - m0, nhit - h0);
      end
   endtask

   task automatic test_hit_priority;
      bit ok, found;
      int base, m0;
      logic [2:0] k;
      next_mole(ok, k);
      m0 = nmiss;
      do_whack((8'b1 << k) | (8'b1 << ((k + 3'd3) % 8)));
      tests++;
      if (!ok || bus.hit_pulse !== 1'b1 || bus.miss_pulse !== 1'b0 || nmiss !== m0) begin
         fails++;
         $display("FAIL t4_multi_bits: got hit=%b miss=%b, want 1/0",
                  bus.hit_pulse, bus.miss_pulse);
      end
      next_mole(ok, k);
      base = nticks;
      m0 = nmiss;
      for (int i = 0; i < 100 && nticks - base < 4; i++) step();
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #2;
         if (bus.tick_ms) begin
            found = 1'b1;
            break;
         end
      end
      bus.whack = 8'b1 << k;
      @(posedge clk);
      #2 bus.whack = 8'd0;
      step();
      tests++;
      if (!ok || !found || nticks - base !== 5) begin
         fails++;
         $display("FAIL t4_align: got %0d ticks, want whack on tick 5", nticks - base);
      end
      tests++;
      if (bus.hit_pulse !== 1'b1 || bus.miss_pulse !== 1'b0) begin
         fails++;
         $display("FAIL t4_tmo_hit: got hit=%b miss=%b, want 1/0",
                  bus.hit_pulse, bus.miss_pulse);
      end
      repeat (4) step();
      tests++;
      if (nmiss !== m0) begin
         fails++;
         $display("FAIL t4_tmo_nomiss: got %0d misses, want 0", nmiss - m0);
      end
   endtask

   task automatic test_enable_drop;
      bit ok;
      int base, m0, h0;
      logic [2:0] k;
      next_mole(ok, k);
      tests++;
      if (!ok || bus.active_idx !== k) begin
         fails++;
         $display("FAIL t5_idx: got %0d, want %0d", bus.active_idx, k);
      end
      @(posedge clk);
      #2 bus.enable = 1'b0;
      @(posedge clk);
      step();
      tests++;
      if (bus.mole_leds !== 8'd0 || bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin
         fails++;
         $display("FAIL t5_drop: got leds=%h hit=%b miss=%b, want 00/0/0",
                  bus.mole_leds, bus.hit_pulse, bus.miss_pulse);
      end
      m0 = nmiss;
      h0 = nhit;
      repeat (30) step();
      tests++;
      if (bus.mole_leds !== 8'd0 || nmiss !== m0 || nhit !== h0) begin
         fails++;
         $display("FAIL t5_idle: got leds=%h %0d pulses, want 00/0",
                  bus.mole_leds, nmiss - m0 + nhit - h0);
      end
      @(posedge clk);
      #2 bus.enable = 1'b1;
      @(posedge clk);
      step();
      base = nticks;
      next_mole(ok, k);
      tests++;
      if (!ok || nticks - base !== 3 || bus.active_idx !== k) begin
         fails++;
         $display("FAIL t5_reenable: got %0d ticks idx=%0d, want 3/%0d",
                  nticks - base, bus.active_idx, k);
      end
   endtask

   task automatic test_reset_and_picks;
      bit ok;
      int mism, reps, tmo;
      logic [2:0] k, last;
      logic [7:0] seen;
      repeat (2) step();
      @(posedge clk);
      #2 rst_n = 1'b0;
      prev_m = 3'd0;
      #1;
      tests++;
      if ({bus.mole_leds, bus.active_idx, bus.hit_pulse, bus.miss_pulse} !== 13'd0) begin
         fails++;
         $display("FAIL t6_async_reset: got leds=%h idx=%0d hit=%b miss=%b, want 0",
                  bus.mole_leds, bus.active_idx, bus.hit_pulse, bus.miss_pulse);
      end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      mism = 0;
      reps = 0;
      tmo = 0;
      seen = 8'd0;
      last = 3'd0;
      for (int i = 0; i < 200; i++) begin
         next_mole(ok, k);
         if (!ok) tmo++;
         if (bus.active_idx !== k) mism++;
         if (bus.active_idx === last) reps++;
         seen[bus.active_idx] = 1'b1;
         last = bus.active_idx;
         wait_leds(1'b0, ok);
         if (!ok) tmo++;
      end
      tests++;
      if (tmo !== 0) begin fails++; $display("FAIL t6_wait: got %0d timeouts, want 0", tmo); end
      tests++;
      if (mism !== 0) begin fails++; $display("FAIL t6_model: got %0d mismatches, want 0", mism); end
      tests++;
      if (reps !== 0) begin fails++; $display("FAIL t6_repeat: got %0d repeats, want 0", reps); end
      tests++;
      if (seen !== 8'hFF) begin fails++; $display("FAIL t6_coverage: got seen=%h, want ff", seen); end
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.difficulty = 2'd0;
      bus.whack = 8'd0;
      repeat (3) @(posedge clk);
      test_reset;
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick_en = 1'b1;
      test_timeout;
      test_hit;
      test_wrong;
      test_hit_priority;
      test_enable_drop;
      test_reset_and_picks;
      tests++;
      if (nboth !== 0) begin
         fails++;
         $display("FAIL pulse_overlap: got %0d cycles, want 0", nboth);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
